rx_decoder: RTL and testbench

//  Receive-side USB full-speed line decoder; companion to the transmit encoder.

---
 rtl/rx_decoder.sv | 139 +++++++++++++
 tb/tb_rx_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_decoder.sv
// rtl/rx_decoder.sv - USB full-speed receive line decoder
// Synchronises D+/D-, recovers bit timing from edges, NRZI-decodes, unstuffs and detects EOP.
`timescale 1ns/1ps
module rx_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic dplus_in,
  input  logic dminus_in,
  output logic d_orig,
  output logic new_bit,
  output logic eop,
  output logic stuff_err,
  output logic rcving
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, RECV, EOP1, EOP2, ERR} state_t;

  state_t          state_q;
  logic            dp_meta_q, dp_s_q, dm_meta_q, dm_s_q, dp_dly_q;
  logic            prev_dp_q;
  logic [2:0]      ones_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic            d_orig_q, new_bit_q, eop_q, stuff_err_q, rcving_q;

  logic line_edge, sample, se0, se1, line_j, line_k, raw_bit;

  assign line_edge = (dp_s_q != dp_dly_q);
  assign se0       = ~dp_s_q & ~dm_s_q;
  assign se1       =  dp_s_q &  dm_s_q;
  assign line_j    =  dp_s_q & ~dm_s_q;
  assign line_k    = ~dp_s_q &  dm_s_q;
  assign raw_bit   = (dp_s_q == prev_dp_q);

  // An edge in the same cycle as the sample point suppresses the sample.
  assign sample = (state_q != IDLE) && (timer_q == TW'(SAMPLE_PT)) && !line_edge;

  always_comb begin
    timer_d = timer_q + TW'(1);
    if (line_edge || state_q == IDLE || timer_q == TW'(CLKS_PER_BIT - 1))
      timer_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta_q   <= 1'b1;
      dp_s_q      <= 1'b1;
      dm_meta_q   <= 1'b0;
      dm_s_q      <= 1'b0;
      dp_dly_q    <= 1'b1;
      prev_dp_q   <= 1'b1;
      ones_q      <= 3'd0;
      timer_q     <= '0;
      state_q     <= IDLE;
      d_orig_q    <= 1'b1;
      new_bit_q   <= 1'b0;
      eop_q       <= 1'b0;
      stuff_err_q <= 1'b0;
      rcving_q    <= 1'b0;
    end else begin
      dp_meta_q   <= dplus_in;
      dp_s_q      <= dp_meta_q;
      dm_meta_q   <= dminus_in;
      dm_s_q      <= dm_meta_q;
      dp_dly_q    <= dp_s_q;
      timer_q     <= timer_d;
      new_bit_q   <= 1'b0;
      eop_q       <= 1'b0;
      stuff_err_q <= 1'b0;

      if (sample && !se0)
        prev_dp_q <= dp_s_q;

      case (state_q)
        IDLE: begin
          if (line_edge && line_k) begin
            state_q   <= RECV;
            prev_dp_q <= 1'b1;
            ones_q    <= 3'd0;
            rcving_q  <= 1'b1;
          end
        end
        RECV: begin
          if (sample) begin
            if (se0) begin
              state_q <= EOP1;
            end else if (se1) begin
              state_q <= ERR;
            end else if (ones_q == 3'd6) begin
              // Bit after six ones must be a stuffed zero; a one is a violation.
              ones_q <= 3'd0;
              if (raw_bit) begin
                stuff_err_q <= 1'b1;
                state_q     <= ERR;
              end
            end else begin
              new_bit_q <= 1'b1;
              d_orig_q  <= raw_bit;
              ones_q    <= raw_bit ? ones_q + 3'd1 : 3'd0;
            end
          end
        end
        EOP1: begin
          if (sample)
            state_q <= se0 ? EOP2 : ERR;
        end
        EOP2: begin
          if (sample && !se0) begin
            if (line_j) begin
              eop_q     <= 1'b1;
              state_q   <= IDLE;
              prev_dp_q <= 1'b1;
              ones_q    <= 3'd0;
              rcving_q  <= 1'b0;
            end else begin
              state_q <= ERR;
            end
          end
        end
        ERR: begin
          if (sample && se0)
            state_q <= EOP1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_orig    = d_orig_q;
  assign new_bit   = new_bit_q;
  assign eop       = eop_q;
  assign stuff_err = stuff_err_q;
  assign rcving    = rcving_q;

endmodule

// File: tb/tb_rx_decoder.sv
// tb/tb_rx_decoder.sv - self-checking bench for rx_decoder
// Packets are built by a transmit-side NRZI/stuffing encoder; expected bits are the unencoded payload.
`timescale 1ns/1ps
module tb_rx_decoder;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic dplus_in = 1'b1;
  logic dminus_in = 1'b0;
  logic d_orig, new_bit, eop, stuff_err, rcving;

  int total = 0;
  int bad = 0;

  localparam logic [1:0] SJ  = 2'b10;
  localparam logic [1:0] SK  = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  always #5 clk = ~clk;

  rx_decoder #(.CLKS_PER_BIT(8), .SAMPLE_PT(4)) dut (
    .clk(clk), .n_rst(n_rst), .dplus_in(dplus_in), .dminus_in(dminus_in),
    .d_orig(d_orig), .new_bit(new_bit), .eop(eop), .stuff_err(stuff_err), .rcving(rcving)
  );

  logic [1:0] syms[$];
  bit         got_bits[$];
  int         n_eop = 0, n_serr = 0, viol = 0, rcv_cycles = 0;
  logic       prev_nb = 1'b0, prev_eop = 1'b0, prev_se = 1'b0, prev_rcv = 1'b0;

  always @(negedge clk) begin
    if (!n_rst) begin
      prev_nb = 1'b0; prev_eop = 1'b0; prev_se = 1'b0; prev_rcv = 1'b0;
    end else begin
      if (new_bit) got_bits.push_back(d_orig);
      if (eop) n_eop++;
      if (stuff_err) n_serr++;
      if (int'(new_bit) + int'(eop) + int'(stuff_err) > 1) viol++;
      if ((new_bit && prev_nb) || (eop && prev_eop) || (stuff_err && prev_se)) viol++;
      if (eop && (rcving || !prev_rcv)) viol++;
      if (rcving) rcv_cycles++;
      prev_nb = new_bit; prev_eop = eop; prev_se = stuff_err; prev_rcv = rcving;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] toggle(input logic [1:0] s);
    return (s == SJ) ? SK : SJ;
  endfunction

  // Transmit-side encoder: NRZI (0 = transition), optional stuffing after six ones.
  task automatic add_packet(input logic [63:0] v, input int n, input bit stuff, input bit with_eop);
    logic [1:0] cur = SJ;
    int ones = 0;
    for (int i = 0; i < n; i++) begin
      if (v[i]) begin
        ones++;
        syms.push_back(cur);
        if (stuff && ones == 6) begin
          cur = toggle(cur);
          syms.push_back(cur);
          ones = 0;
        end
      end else begin
        cur = toggle(cur);
        syms.push_back(cur);
        ones = 0;
      end
    end
    if (with_eop) begin
      syms.push_back(SE0); syms.push_back(SE0); syms.push_back(SJ);
    end
  endtask

  // Each boundary moves by -1..+1 clk without accumulating.
  task automatic drive(input bit jit, input int limit);
    int jp = 0;
    int jn;
    for (int i = 0; i < syms.size() && i < limit; i++) begin
      jn = (!jit || i == syms.size() - 1) ? 0 : int'($urandom_range(0, 2)) - 1;
      {dplus_in, dminus_in} = syms[i];
      repeat (8 + jn - jp) @(posedge clk);
      #1;
      jp = jn;
    end
    syms.delete();
  endtask

  task automatic idle(input int bits);
    {dplus_in, dminus_in} = SJ;
    repeat (8 * bits) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] bits_since(input int base);
    logic [63:0] r = '0;
    for (int i = base; i < got_bits.size() && i - base < 64; i++)
      r[i - base] = got_bits[i];
    return r;
  endfunction

  task automatic run_packet(input string tag, input logic [63:0] v, input int n, input bit jit);
    int base = got_bits.size();
    int e0 = n_eop;
    int s0 = n_serr;
    add_packet(v, n, 1'b1, 1'b1);
    drive(jit, 1000);
    idle(3);
    check({tag, "_nbits"}, 64'(got_bits.size() - base), 64'(n));
    check({tag, "_bits"}, bits_since(base), v);
    check({tag, "_eop"}, 64'(n_eop - e0), 64'd1);
    check({tag, "_serr"}, 64'(n_serr - s0), 64'd0);
    check({tag, "_rcving"}, 64'(rcving), 64'd0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int base, e0, s0, r0, nb;
    logic [63:0] v;
    logic [7:0] b;

    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_orig", 64'(d_orig), 64'd1);
    check("rst_new_bit", 64'(new_bit), 64'd0);
    check("rst_eop", 64'(eop), 64'd0);
    check("rst_stuff_err", 64'(stuff_err), 64'd0);
    check("rst_rcving", 64'(rcving), 64'd0);
    n_rst = 1'b1;

    base = got_bits.size(); e0 = n_eop; s0 = n_serr; r0 = rcv_cycles;
    idle(100);
    check("idle_bits", 64'(got_bits.size() - base), 64'd0);
    check("idle_eop", 64'(n_eop - e0), 64'd0);
    check("idle_serr", 64'(n_serr - s0), 64'd0);
    check("idle_rcv_cycles", 64'(rcv_cycles - r0), 64'd0);

    run_packet("a5", 64'hA580, 16, 1'b0);
    run_packet("ff_stuffed", 64'hFF80, 16, 1'b0);

    // Sync's trailing 1 plus five data ones reach the limit; the next one violates.
    base = got_bits.size(); e0 = n_eop; s0 = n_serr;
    add_packet(64'h7F80, 15, 1'b0, 1'b1);
    drive(1'b0, 1000);
    idle(3);
    check("seven_nbits", 64'(got_bits.size() - base), 64'd13);
    check("seven_bits", bits_since(base), 64'h1F80);
    check("seven_serr", 64'(n_serr - s0), 64'd1);
    check("seven_eop", 64'(n_eop - e0), 64'd1);
    check("seven_rcving", 64'(rcving), 64'd0);

    base = got_bits.size(); e0 = n_eop; s0 = n_serr;
    add_packet(64'hA580, 16, 1'b1, 1'b0);
    syms.push_back(SE0); syms.push_back(SJ); syms.push_back(SJ);
    drive(1'b0, 1000);
    idle(2);
    check("se0x1_nbits", 64'(got_bits.size() - base), 64'd16);
    check("se0x1_eop", 64'(n_eop - e0), 64'd0);
    check("se0x1_rcving", 64'(rcving), 64'd1);
    syms.push_back(SE0); syms.push_back(SE0); syms.push_back(SJ);
    drive(1'b0, 1000);
    idle(3);
    check("se0x1_term_eop", 64'(n_eop - e0), 64'd1);
    check("se0x1_term_nbits", 64'(got_bits.size() - base), 64'd16);
    check("se0x1_term_serr", 64'(n_serr - s0), 64'd0);
    check("se0x1_term_rcving", 64'(rcving), 64'd0);

    run_packet("jitter", 64'h3C_FF_A5_80, 32, 1'b1);

    for (int k = 0; k < 8; k++) begin
      nb = int'($urandom_range(1, 4));
      v = 64'h80;
      for (int i = 0; i < nb; i++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        v = v | (64'(b) << (8 + 8 * i));
      end
      run_packet($sformatf("rnd%0d", k), v, 8 + 8 * nb, k[0]);
    end

    e0 = n_eop;
    add_packet(64'hA580, 16, 1'b1, 1'b1);
    drive(1'b0, 12);
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_d_orig", 64'(d_orig), 64'd1);
    check("midrst_new_bit", 64'(new_bit), 64'd0);
    check("midrst_eop", 64'(eop), 64'd0);
    check("midrst_stuff_err", 64'(stuff_err), 64'd0);
    check("midrst_rcving", 64'(rcving), 64'd0);
    {dplus_in, dminus_in} = SJ;
    repeat (4) @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(2);
    check("midrst_no_eop", 64'(n_eop - e0), 64'd0);
    run_packet("post_rst", 64'h3C80, 16, 1'b0);

    check("strobe_rules", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
